// File: rtl/lcv_mac_frame_acc.sv
// Frame accumulator behind the 33-bit MAC stage: sums the beats of each frame with
// per-beat saturation and emits one result (sum, beat count, sat flag) per frame.
module lcv_mac_frame_acc #(
  parameter int IN_WIDTH  = 33,
  parameter int ACC_WIDTH = 40,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_sat
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  state_t                 state_q;
  logic [ACC_WIDTH-1:0]   acc_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic                   sticky_q;
  logic                   out_valid_q;
  logic [ACC_WIDTH-1:0]   out_data_q;
  logic [CNT_WIDTH-1:0]   out_count_q;
  logic                   out_sat_q;

  logic                   accept;
  logic [ACC_WIDTH-1:0]   acc_base;
  logic [ACC_WIDTH:0]     sum_d;
  logic                   sat_now_d;
  logic [ACC_WIDTH-1:0]   clamped_d;
  logic [CNT_WIDTH-1:0]   cnt_d;

  assign in_ready = rst && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // In IDLE the accumulator is zero by construction; gating it keeps a frame start clean.
  assign acc_base  = (state_q == IDLE) ? '0 : acc_q;
  assign sum_d     = {acc_base[ACC_WIDTH-1], acc_base}
                   + {{(ACC_WIDTH+1-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
  assign sat_now_d = sum_d[ACC_WIDTH] ^ sum_d[ACC_WIDTH-1];
  assign clamped_d = !sat_now_d ? sum_d[ACC_WIDTH-1:0]
                   : (sum_d[ACC_WIDTH] ? ACC_MIN : ACC_MAX);
  assign cnt_d     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (flush) begin
        state_q  <= IDLE;
        acc_q    <= '0;
        cnt_q    <= '0;
        sticky_q <= 1'b0;
      end else if (accept) begin
        if (in_last) begin
          state_q     <= IDLE;
          acc_q       <= '0;
          cnt_q       <= '0;
          sticky_q    <= 1'b0;
          out_valid_q <= 1'b1;
          out_data_q  <= clamped_d;
          out_count_q <= cnt_d;
          out_sat_q   <= sticky_q | sat_now_d;
        end else begin
          state_q  <= ACCUM;
          acc_q    <= clamped_d;
          cnt_q    <= cnt_d;
          sticky_q <= sticky_q | sat_now_d;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_sat   = out_sat_q;

endmodule
